led_pattern_checker: RTL
========================

Name: led_pattern_checker

Overview:
- Receive-side checker for the 3-bit rotating light-pattern stream {bar, mosca, azul} produced by the LED pattern generator.
- Samples the symbol stream, finds the phase of the 10-symbol cycle, locks onto it and then checks every later symbol against the expected one.
- Reports lock, phase, per-symbol mismatches and a saturating error count.
- Sits at the far end of the LED bus, in the bench and in hardware self-test.

Parameters:
- PERIOD, 10, symbols per pattern cycle. Fixed at 10 for the current pattern constants.
- LOSS_THRESH, 3, consecutive mismatches that force loss of lock (range 1..15).
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- valid_in  input  1  sample strobe; led_in is consumed only on edges where valid_in=1.
- led_in  input  3  received symbol; bit2=bar, bit1=mosca, bit0=azul.
- locked  output  1  1 while in LOCKED.
- phase  output  4  index (0..9) of the next expected symbol; meaningful only while locked=1.
- mismatch  output  1  one-cycle pulse: the sample just checked in LOCKED was wrong.
- frame  output  1  one-cycle pulse: a correct s[9] was received in LOCKED.
- err_count  output  ERR_W  total mismatches since reset; saturates at all-ones.

Behaviour:
- Pattern constants:
  - BAR = 10'b0010011110
  - MOSCA = 10'b0110101100
  - AZUL = 10'b1010101000
- Symbol definition: s[i] = {BAR[i], MOSCA[i], AZUL[i]}, i = 0..9, transmitted LSB first.
- Resulting symbols: s0=000, s1=100, s2=110, s3=111, s4=100, s5=011, s6=000, s7=111, s8=010, s9=001. No two rotations are equal.
- Reset values: state=HUNT, locked=0, phase=0, mismatch=0, frame=0, err_count=0, history window cleared, fill counter=0, miss run=0.
- Reset wins over valid_in on the same edge, including in the middle of a lock.
- valid_in=0: all state holds and pulses are 0.
- HUNT state:
  - Each valid sample shifts into a 10-symbol window (oldest to newest). The fill counter saturates at 10.
  - Compare only when the fill counter, including the current sample, reaches 10.
  - The window after the shift is compared against all 10 rotations in parallel.
  - Rotation r means window = s[r], s[r+1], …, s[r+9] (indices mod 10).
  - On a match: go to LOCKED on that edge and set phase=r. The newest symbol was s[(r+9) mod 10], so the next expected symbol is s[r].
  - If more than one rotation matches, the lowest r wins. This is only a guard; it does not happen with the current constants.
  - locked rises on the edge that captures the 10th matching sample, so it is visible one cycle after that sample is presented.
  - No mismatch or frame pulses and no err_count changes in HUNT.
- LOCKED state, on each valid sample:
  - Compare led_in with s[phase].
  - phase always advances: 9 wraps to 0. The stream is assumed free of slips.
  - Match: miss run := 0. frame=1 if phase was 9.
  - Mismatch: mismatch=1, err_count +1 (saturating), miss run +1.
  - If miss run reaches LOSS_THRESH: go to HUNT on that edge, locked=0, window and fill counter cleared. The mismatch pulse and count for that sample still occur.
- Pulses are registered: they are high for exactly the cycle after the edge that consumed the sample.
- err_count holds across loss and reacquisition of lock; only reset clears it.

Decomposition:
- Shared package/include holds:
  - PERIOD and the BAR, MOSCA, AZUL constants (shared with the generator).
  - The symbol-extraction function s(i).
  - State encoding: HUNT=0, LOCKED=1.
- One sub-module, pattern_phase_finder:
  - Contains the 10-symbol window, the fill counter and the 10 parallel rotation comparators.
  - Outputs hit and r[3:0].
  - Has a clear input that the top uses on loss of lock.
- The top holds the FSM, phase pointer, miss run, error counter and pulse registers.

Test Plan:
- Aligned lock: after reset, 10 valid samples s0..s9 → locked=1 and phase=0 one cycle after the 10th sample. Continuing s0..s9 → mismatch never asserts, frame pulses once per 10 samples (on s9), err_count=0.
- Mid-cycle lock with gaps: s3..s9, s0, s1, s2 with valid_in low every other cycle → locked=1, phase=3. Values hold during the gaps. Next s3 is accepted without error.
- Single error: while locked, send 101 in place of s5 → mismatch pulses once, err_count=1, locked stays 1. The next sample s6 is accepted and phase=7 afterwards.
- Loss and reacquire: 3 consecutive wrong symbols → err_count=3, locked=0 after the third. Then 10 samples starting at s7 → locked=1, phase=7, err_count still 3.
- Reset mid-lock: assert reset for one cycle while locked at phase 4 → the next cycle shows locked=0, phase=0, err_count=0, no pulses. A full 10-sample window is needed before locking again.
- Saturation: with ERR_W=4, send 20 mismatches with LOSS_THRESH=15 and relock between bursts → err_count stops at 15 and does not wrap.

Source files
------------

// File: rtl/led_pattern_checker_pkg.sv
// Shared definitions for the LED pattern stream {bar, mosca, azul}.
// Holds the pattern period, the three per-lane pattern constants (also used by
// the generator), the symbol-extraction helper and the checker state encoding.
package led_pattern_checker_pkg;

  localparam int PERIOD = 10;

  // Per-lane patterns, transmitted LSB first.
  localparam logic [9:0] BAR   = 10'b0010011110;
  localparam logic [9:0] MOSCA = 10'b0110101100;
  localparam logic [9:0] AZUL  = 10'b1010101000;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Symbol i of the cycle as {bar, mosca, azul}; i must be in 0..PERIOD-1.
  function automatic logic [2:0] sym(input logic [3:0] i);
    return {BAR[i], MOSCA[i], AZUL[i]};
  endfunction

endpackage

// File: rtl/led_pattern_checker_phase_finder.sv
// pattern_phase_finder: acquisition half of the LED pattern checker.
// Keeps a window of the last PERIOD symbols (oldest at index 0) and compares the
// window as it will look after the current sample against every rotation of
// the pattern in parallel.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           empties window and fill counter (used on loss of lock)
//   enable          window only advances while the checker is hunting
//   valid_in        sample strobe
//   led_in [2:0]    received symbol {bar, mosca, azul}
//   hit             a rotation matches the window including led_in (combinational)
//   r [3:0]         lowest matching rotation; valid when hit=1
module pattern_phase_finder (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       valid_in,
  input  logic [2:0] led_in,
  output logic       hit,
  output logic [3:0] r
);
  import led_pattern_checker_pkg::*;

  localparam logic [3:0] FULL = 4'(PERIOD);

  logic [2:0]        win_reg  [PERIOD];
  logic [2:0]        win_next [PERIOD];
  logic [3:0]        fill_reg;
  logic [3:0]        fill_next;
  logic [PERIOD-1:0] match;

  // Window and fill count as they would be after accepting led_in.
  always_comb begin
    for (int k = 0; k < PERIOD - 1; k++) begin
      win_next[k] = win_reg[k+1];
    end
    win_next[PERIOD-1] = led_in;
    fill_next = (fill_reg == FULL) ? fill_reg : fill_reg + 4'd1;
  end

  // Rotation gi expects window[k] = s[(gi + k) mod PERIOD].
  generate
    for (genvar gi = 0; gi < PERIOD; gi++) begin : g_rot
      logic rot_match;
      always_comb begin
        rot_match = 1'b1;
        for (int k = 0; k < PERIOD; k++) begin
          if (win_next[k] != sym(4'((gi + k) % PERIOD))) begin
            rot_match = 1'b0;
          end
        end
      end
      assign match[gi] = rot_match;
    end
  endgenerate

  // Scan downward so the lowest matching rotation is the one left in r.
  always_comb begin
    hit = 1'b0;
    r   = 4'd0;
    if (enable && valid_in && (fill_next == FULL)) begin
      for (int k = PERIOD - 1; k >= 0; k--) begin
        if (match[k]) begin
          hit = 1'b1;
          r   = 4'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < PERIOD; k++) begin
        win_reg[k] <= 3'd0;
      end
      fill_reg <= 4'd0;
    end else if (enable && valid_in) begin
      for (int k = 0; k < PERIOD; k++) begin
        win_reg[k] <= win_next[k];
      end
      fill_reg <= fill_next;
    end
  end

endmodule

// File: rtl/led_pattern_checker.sv
// led_pattern_checker: receive-side checker for the rotating LED pattern.
// Hunts for the phase of the 10-symbol cycle, locks onto it, then checks every
// later valid symbol against the expected one.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   valid_in           sample strobe; led_in consumed only when high
//   led_in [2:0]       received symbol {bar, mosca, azul}
//   locked             high while in LOCKED
//   phase [3:0]        index of the next expected symbol (valid while locked)
//   mismatch           one-cycle pulse: last checked sample was wrong
//   frame              one-cycle pulse: a correct s[9] was received
//   err_count [ERR_W]  saturating count of mismatches since reset
module led_pattern_checker #(
  parameter int PERIOD      = 10,
  parameter int LOSS_THRESH = 3,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [2:0]       led_in,
  output logic             locked,
  output logic [3:0]       phase,
  output logic             mismatch,
  output logic             frame,
  output logic [ERR_W-1:0] err_count
);
  import led_pattern_checker_pkg::state_t;
  import led_pattern_checker_pkg::HUNT;
  import led_pattern_checker_pkg::LOCKED;
  import led_pattern_checker_pkg::sym;

  localparam logic [3:0] LAST_PHASE = 4'(PERIOD - 1);
  localparam logic [3:0] THRESH     = 4'(LOSS_THRESH);

  state_t           state_reg;
  logic [3:0]       phase_reg;
  logic [3:0]       miss_reg;
  logic [ERR_W-1:0] err_reg;
  logic             mismatch_reg;
  logic             frame_reg;

  logic             hit;
  logic [3:0]       hit_r;
  logic             sample_ok;
  logic [3:0]       miss_next;
  logic             lose_lock;

  pattern_phase_finder u_finder (
    .clk      (clk),
    .reset    (reset),
    .clear    (lose_lock),
    .enable   (state_reg == HUNT),
    .valid_in (valid_in),
    .led_in   (led_in),
    .hit      (hit),
    .r        (hit_r)
  );

  always_comb begin
    sample_ok = (led_in == sym(phase_reg));
    miss_next = miss_reg + 4'd1;
    // The sample that completes a run of LOSS_THRESH misses drops the lock.
    lose_lock = valid_in && (state_reg == LOCKED) && !sample_ok
                && (miss_next == THRESH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= HUNT;
      phase_reg    <= 4'd0;
      miss_reg     <= 4'd0;
      err_reg      <= '0;
      mismatch_reg <= 1'b0;
      frame_reg    <= 1'b0;
    end else begin
      mismatch_reg <= 1'b0;
      frame_reg    <= 1'b0;
      if (valid_in) begin
        case (state_reg)
          HUNT: begin
            if (hit) begin
              state_reg <= LOCKED;
              phase_reg <= hit_r;
              miss_reg  <= 4'd0;
            end
          end
          LOCKED: begin
            // No slip correction: phase advances on every sample.
            phase_reg <= (phase_reg == LAST_PHASE) ? 4'd0 : phase_reg + 4'd1;
            if (sample_ok) begin
              miss_reg  <= 4'd0;
              frame_reg <= (phase_reg == LAST_PHASE);
            end else begin
              mismatch_reg <= 1'b1;
              miss_reg     <= miss_next;
              if (err_reg != '1) begin
                err_reg <= err_reg + {{(ERR_W-1){1'b0}}, 1'b1};
              end
              if (lose_lock) begin
                state_reg <= HUNT;
              end
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign locked    = (state_reg == LOCKED);
  assign phase     = phase_reg;
  assign mismatch  = mismatch_reg;
  assign frame     = frame_reg;
  assign err_count = err_reg;

endmodule
